alu_sequencer: RTL and testbench

- Multi-cycle FSM controller that accepts 16-bit instructions over a valid/ready handshake and owns a 4x8 register file.
- Sequences the existing 8-bit alu through DECODE, EXECUTE and WRITEBACK, then writes the result back to the register file.
- Sits between the instruction source (fetch logic or testbench) and the alu datapath. Reports results and status flags.

---
 rtl/risc_pkg.sv | 35 +++
 rtl/alu.sv | 26 ++
 rtl/risc_regfile.sv | 40 ++++
 rtl/alu_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, instruction fields.
`default_nettype none

package risc_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_NOT     = 3'd4;
  localparam logic [2:0] OP_LDI     = 3'd5;
  localparam logic [2:0] OP_NOP     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_LO  = 11;
  localparam int RS1_LO = 9;
  localparam int RSV    = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RS2_LO = 0;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// Combinational 8-bit ALU; alu_control selects ADD/SUB/AND/OR/NOT.
`default_nettype none

module alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    case (alu_control)
      3'd0:    result = a + b;
      3'd1:    result = a - b;
      3'd2:    result = a & b;
      3'd3:    result = a | b;
      3'd4:    result = ~a;
      default: result = 'x;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/risc_regfile.sv
// NREG x DATA_W register file: one synchronous write port, two read ports plus a debug read port.
`default_nettype none

module risc_regfile
  import risc_pkg::*;
#(
  parameter int                NREG    = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: accepts an instruction, sequences DECODE/EXEC/WB around the ALU, writes the register file.
`default_nettype none

module alu_sequencer
  import risc_pkg::*;
#(
  parameter int                NREG    = 4,
  parameter logic [DATA_W-1:0] RST_VAL = 8'h00,
  localparam int               AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              busy,
  output logic              res_valid,
  output logic [AW-1:0]     res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              zero_flag,
  output logic              err_illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state, next_state;
  logic [2:0]        op_q;
  logic [AW-1:0]     rd_q, rs1_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, r_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, alu_y;
  logic [2:0]        alu_ctl;
  logic              unused_rsv;

  assign unused_rsv = instr[RSV];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (instr_valid) next_state = DECODE;
      DECODE: begin
        case (op_q)
          OP_LDI:             next_state = WB;
          OP_NOP, OP_ILLEGAL: next_state = IDLE;
          default:            next_state = EXEC;
        endcase
      end
      EXEC:   next_state = WB;
      WB:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result, destination and zero_flag are loaded on entry to WB so they are valid during the res_valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      res_rd      <= '0;
      zero_flag   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) begin
        op_q  <= instr[OP_HI:OP_LO];
        rd_q  <= instr[RD_LO +: AW];
        rs1_q <= instr[RS1_LO +: AW];
        imm_q <= instr[IMM_HI:IMM_LO];
      end
      if (state == DECODE) begin
        a_q <= rdata_a;
        b_q <= rdata_b;
        if (op_q == OP_LDI) begin
          r_q       <= imm_q;
          res_rd    <= rd_q;
          zero_flag <= (imm_q == '0);
        end
        if (op_q == OP_ILLEGAL) err_illegal <= 1'b1;
      end
      if (state == EXEC) begin
        r_q       <= alu_y;
        res_rd    <= rd_q;
        zero_flag <= (alu_y == '0);
      end
    end
  end

  assign alu_ctl     = (state == EXEC) ? op_q : 3'b000;
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == WB);
  assign res_data    = r_q;

  alu #(.WIDTH(DATA_W)) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (alu_ctl),
    .result      (alu_y)
  );

  risc_regfile #(.NREG(NREG), .RST_VAL(RST_VAL)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (state == WB),
    .waddr    (rd_q),
    .wdata    (r_q),
    .raddr_a  (rs1_q),
    .rdata_a  (rdata_a),
    .raddr_b  (imm_q[RS2_LO +: AW]),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random instructions against a reference model.
`default_nettype none

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [1:0]  dbg_addr = 2'd0;
  logic        instr_ready, busy, res_valid, zero_flag, err_illegal;
  logic [1:0]  res_rd;
  logic [7:0]  res_data, dbg_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [4];
  logic       m_zero;
  logic       m_err;

  alu_sequencer #(.NREG(4), .RST_VAL(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .zero_flag   (zero_flag),
    .err_illegal (err_illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input logic [7:0] imm);
    logic [2:0] o = op[2:0];
    logic [1:0] d = rd[1:0];
    logic [1:0] s = rs1[1:0];
    return {o, d, s, 1'b0, imm};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_zero = 1'b0;
    m_err  = 1'b0;
  endfunction

  // Called just after a falling edge; finishes within the low phase.
  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 check(tag, 16'(dbg_data), 16'(m_regs[i]));
    end
  endtask

  // Entered and left on a falling edge with the DUT idle.
  task automatic run_instr(input logic [15:0] w, input bit hold);
    logic [2:0] op  = w[15:13];
    logic [1:0] rd  = w[12:11];
    logic [1:0] rs1 = w[10:9];
    logic [1:0] rs2 = w[1:0];
    logic [7:0] imm = w[7:0];
    logic [7:0] a, b, res;
    int done, wbc, n;
    a = m_regs[rs1];
    b = m_regs[rs2];
    case (op)
      3'd0:    res = 8'((int'(a) + int'(b)) % 256);
      3'd1:    res = 8'((int'(a) - int'(b) + 256) % 256);
      3'd2:    res = a & b;
      3'd3:    res = a | b;
      3'd4:    res = 8'(255 - int'(a));
      3'd5:    res = imm;
      default: res = 8'h00;
    endcase
    done = (op <= 3'd4) ? 4 : (op == 3'd5) ? 3 : 2;
    wbc  = (op <= 3'd5) ? done - 1 : 0;
    if (op == 3'd7) m_err = 1'b1;

    dbg_addr    = rd;
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 16'(instr_ready), 16'd1);
      instr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin
      instr_valid = 1'b0;
      instr       = 16'($urandom);
    end
    for (int c = 1; c <= done; c++) begin
      check("instr_ready", 16'(instr_ready), 16'(c == done));
      check("busy", 16'(busy), 16'(c != done));
      check("res_valid", 16'(res_valid), 16'(c == wbc));
      if (c == wbc) begin
        check("res_rd", 16'(res_rd), 16'(rd));
        check("res_data", 16'(res_data), 16'(res));
        check("zero_in_wb", 16'(zero_flag), 16'(res == 8'h00));
        check("dbg_old_in_wb", 16'(dbg_data), 16'(m_regs[rd]));
        m_regs[rd] = res;
        m_zero     = (res == 8'h00);
      end
      if (c == done) begin
        check("dbg_after", 16'(dbg_data), 16'(m_regs[rd]));
        check("zero_hold", 16'(zero_flag), 16'(m_zero));
        check("err_illegal", 16'(err_illegal), 16'(m_err));
      end
      if (c < done) @(negedge clk);
    end
  endtask

  task automatic reset_mid_add();
    dbg_addr    = 2'd3;
    instr       = mk(0, 3, 1, 8'h02);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ready_async", 16'(instr_ready), 16'd1);
    check("rst_busy_async", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_res_data", 16'(res_data), 16'd0);
    check("rst_err", 16'(err_illegal), 16'd0);
    @(negedge clk);
    check("rst_ready_after", 16'(instr_ready), 16'd1);
    check("rst_res_valid_after", 16'(res_valid), 16'd0);
    check_all_regs("rst_regs");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_res_valid", 16'(res_valid), 16'd0);
    check("reset_res_rd", 16'(res_rd), 16'd0);
    check("reset_res_data", 16'(res_data), 16'd0);
    check("reset_zero", 16'(zero_flag), 16'd0);
    check("reset_err", 16'(err_illegal), 16'd0);
    check("reset_ready", 16'(instr_ready), 16'd1);
    rst = 1'b0;
    @(negedge clk);
    check_all_regs("reset_regs");
    @(negedge clk);

    run_instr(mk(5, 1, 0, 8'h05), 1'b0);
    run_instr(mk(5, 2, 0, 8'h03), 1'b0);
    reset_mid_add();

    run_instr(mk(5, 1, 0, 8'h05), 1'b0);
    run_instr(mk(5, 2, 0, 8'h03), 1'b0);
    run_instr(mk(0, 3, 1, 8'h02), 1'b0);
    check("add_r3_const", 16'(res_data), 16'h0008);
    run_instr(mk(1, 0, 2, 8'h01), 1'b0);
    check("sub_const", 16'(res_data), 16'h00FE);
    run_instr(mk(5, 1, 0, 8'hFF), 1'b0);
    run_instr(mk(4, 0, 1, 8'h00), 1'b0);
    check("not_zero_const", 16'(zero_flag), 16'd1);
    run_instr(mk(5, 2, 0, 8'hF0), 1'b0);
    run_instr(mk(5, 3, 0, 8'h3C), 1'b0);
    run_instr(mk(2, 0, 2, 8'h03), 1'b0);
    check("and_const", 16'(res_data), 16'h0030);
    run_instr(mk(3, 1, 2, 8'h03), 1'b0);
    check("or_const", 16'(res_data), 16'h00FC);

    run_instr(mk(7, 2, 1, 8'hA5) | 16'h0100, 1'b0);
    check_all_regs("illegal_regs");
    @(negedge clk);
    run_instr(mk(6, 3, 0, 8'h11), 1'b0);
    check("err_sticky", 16'(err_illegal), 16'd1);
    check_all_regs("nop_regs");
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_instr(mk(0, i, (i + 1) % 4, 8'(i)), 1'b1);
    instr_valid = 1'b0;

    run_instr(mk(5, 1, 0, 8'h80), 1'b0);
    run_instr(mk(0, 1, 1, 8'h01), 1'b0);
    check("wrap_const", 16'(res_data), 16'h0000);

    for (int i = 0; i < 150; i++) run_instr(16'($urandom), 1'($urandom_range(0, 1)));
    instr_valid = 1'b0;
    check_all_regs("final_regs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
